// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the parametrised vending controller.
//   vend_state_e : controller state encoding (IDLE, CREDIT, VEND, CHANGE)
//   COIN_SEL_*   : coin_sel encodings, COIN_INVALID marks the unused code
//   coin_value() : maps a coin_sel code to its value using the caller's
//                  denomination parameters (0 for the invalid code)
// ---------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_SEL_0   = 2'd0;
  localparam logic [1:0] COIN_SEL_1   = 2'd1;
  localparam logic [1:0] COIN_SEL_2   = 2'd2;
  localparam logic [1:0] COIN_INVALID = 2'd3;

  // Denominations are module parameters, so they are passed in rather than
  // fixed here; this keeps the package usable by differently sized instances.
  function automatic int unsigned coin_value(input logic [1:0]  sel,
                                             input int unsigned val_0,
                                             input int unsigned val_1,
                                             input int unsigned val_2);
    int unsigned v;
    v = 0;
    case (sel)
      COIN_SEL_0: v = val_0;
      COIN_SEL_1: v = val_1;
      COIN_SEL_2: v = val_2;
      default:    v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// ---------------------------------------------------------------------------
// vend_change_unit
// Holds the amount still owed to the customer and runs the one-coin-at-a-time
// refund handshake towards the hopper.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   load_i          : capture load_val_i into the remaining counter
//   load_val_i      : amount owed (credit after a vend, or full credit on cancel)
//   start_i         : begin paying out; change_valid_o rises next cycle if
//                     anything is owed (may coincide with load_i)
//   change_ack_i    : hopper paid one CHANGE_UNIT coin
//   change_valid_o  : registered refund-coin request, held until acked
//   remaining_o     : amount still owed
//   done_o          : combinational; this cycle's ack pays the final coin
// ---------------------------------------------------------------------------
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 7,
  parameter int CHANGE_UNIT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [CREDIT_W-1:0] load_val_i,
  input  logic                start_i,
  input  logic                change_ack_i,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] remaining_o,
  output logic                done_o
);

  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t UNIT = credit_t'(CHANGE_UNIT);

  credit_t remaining_q, remaining_d;
  logic    change_valid_q, change_valid_d;
  credit_t base_rem;
  logic    pay;

  assign pay = change_valid_q && change_ack_i;

  always_comb begin
    remaining_d    = remaining_q;
    change_valid_d = change_valid_q;
    // A load and a start in the same cycle (cancel from CREDIT) must see the
    // freshly loaded amount when deciding whether to raise change_valid.
    base_rem       = load_i ? load_val_i : remaining_q;

    if (load_i) begin
      remaining_d    = load_val_i;
      change_valid_d = 1'b0;
    end else if (pay) begin
      remaining_d    = remaining_q - UNIT;
      change_valid_d = (remaining_q - UNIT) != '0;
    end

    if (start_i) begin
      change_valid_d = base_rem != '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q    <= '0;
      change_valid_q <= 1'b0;
    end else begin
      remaining_q    <= remaining_d;
      change_valid_q <= change_valid_d;
    end
  end

  assign change_valid_o = change_valid_q;
  assign remaining_o    = remaining_q;
  assign done_o         = pay && (remaining_q == UNIT);

endmodule

// File: rtl/vending_fsm_param.sv
// ---------------------------------------------------------------------------
// vending_fsm_param
// Vending controller: accumulates coin credit, vends one of two items over a
// valid/ack handshake and refunds change / cancelled credit one CHANGE_UNIT
// coin at a time through vend_change_unit.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   coin_valid/sel  : one-cycle coin event and its denomination code
//   sel_valid/item  : one-cycle item selection and item index
//   cancel          : one-cycle refund request
//   dispense_ack    : dispenser accepted the item
//   change_ack      : hopper paid one refund coin
//   dispense_valid  : item request, held until dispense_ack
//   dispense_item   : item index, stable while dispense_valid
//   change_valid    : refund coin request, held until change_ack
//   coin_reject     : one-cycle pulse, coin returned uncredited
//   insufficient    : one-cycle pulse, selection refused for low credit
//   credit          : current credit
//   busy            : high in VEND and CHANGE
// All outputs are registered.
// ---------------------------------------------------------------------------
module vending_fsm_param
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 7,
  parameter int MAX_CREDIT  = 60,
  parameter int COIN_VAL_0  = 5,
  parameter int COIN_VAL_1  = 10,
  parameter int COIN_VAL_2  = 25,
  parameter int PRICE_0     = 15,
  parameter int PRICE_1     = 20,
  parameter int CHANGE_UNIT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                sel_valid,
  input  logic                sel_item,
  input  logic                cancel,
  input  logic                dispense_ack,
  input  logic                change_ack,
  output logic                dispense_valid,
  output logic                dispense_item,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                insufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Parameter sanity: refunds are paid in whole CHANGE_UNIT coins, so every
  // amount that can end up in credit must be a multiple of it.
  if (CHANGE_UNIT <= 0 ||
      (COIN_VAL_0 % CHANGE_UNIT) != 0 || (COIN_VAL_1 % CHANGE_UNIT) != 0 ||
      (COIN_VAL_2 % CHANGE_UNIT) != 0 || (PRICE_0 % CHANGE_UNIT) != 0 ||
      (PRICE_1 % CHANGE_UNIT) != 0) begin : g_bad_unit
    $error("vending_fsm_param: coin values and prices must be multiples of CHANGE_UNIT");
  end
  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vending_fsm_param: CREDIT_W too narrow for MAX_CREDIT");
  end

  typedef logic [CREDIT_W-1:0] credit_t;
  // One extra bit so credit + coin can be compared against MAX_CREDIT
  // without wrapping.
  typedef logic [CREDIT_W:0]   wide_t;

  localparam wide_t   MAX_W   = wide_t'(MAX_CREDIT);
  localparam wide_t   PRICE0W = wide_t'(PRICE_0);
  localparam wide_t   PRICE1W = wide_t'(PRICE_1);
  localparam credit_t UNIT    = credit_t'(CHANGE_UNIT);

  vend_state_e state_q, state_d;
  credit_t     credit_q, credit_d;
  logic        dispense_valid_q, dispense_valid_d;
  logic        dispense_item_q, dispense_item_d;
  logic        coin_reject_q, coin_reject_d;
  logic        insufficient_q, insufficient_d;
  logic        busy_q, busy_d;

  // Change unit control
  logic        cu_load;
  credit_t     cu_load_val;
  logic        cu_start;
  logic        cu_valid;
  credit_t     cu_remaining;
  logic        cu_done;

  wide_t       coin_w;
  wide_t       sum_w;
  wide_t       price_w;

  assign coin_w  = wide_t'(coin_value(coin_sel, COIN_VAL_0, COIN_VAL_1, COIN_VAL_2));
  assign sum_w   = wide_t'(credit_q) + coin_w;
  assign price_w = sel_item ? PRICE1W : PRICE0W;

  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    dispense_valid_d = dispense_valid_q;
    dispense_item_d  = dispense_item_q;
    coin_reject_d    = 1'b0;
    insufficient_d   = 1'b0;
    cu_load          = 1'b0;
    cu_load_val      = '0;
    cu_start         = 1'b0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          // Cancel wins arbitration; in IDLE there is nothing to refund.
          if (state_q == ST_CREDIT) begin
            cu_load     = 1'b1;
            cu_load_val = credit_q;
            cu_start    = 1'b1;
            state_d     = ST_CHANGE;
          end
          coin_reject_d = coin_valid;
        end else if (sel_valid) begin
          // IDLE always holds credit 0, so the same compare covers it.
          if (wide_t'(credit_q) >= price_w) begin
            state_d          = ST_VEND;
            dispense_valid_d = 1'b1;
            dispense_item_d  = sel_item;
            cu_load          = 1'b1;
            cu_load_val      = credit_t'(wide_t'(credit_q) - price_w);
          end else begin
            insufficient_d = 1'b1;
          end
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_sel == COIN_INVALID || sum_w > MAX_W) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = credit_t'(sum_w);
            state_d  = ST_CREDIT;
          end
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_valid;
        if (dispense_ack) begin
          dispense_valid_d = 1'b0;
          credit_d         = cu_remaining;
          if (cu_remaining != '0) begin
            cu_start = 1'b1;
            state_d  = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (cu_valid && change_ack) begin
          credit_d = credit_q - UNIT;
          if (cu_done) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      credit_q         <= '0;
      dispense_valid_q <= 1'b0;
      dispense_item_q  <= 1'b0;
      coin_reject_q    <= 1'b0;
      insufficient_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_item_q  <= dispense_item_d;
      coin_reject_q    <= coin_reject_d;
      insufficient_q   <= insufficient_d;
      busy_q           <= busy_d;
    end
  end

  vend_change_unit #(
    .CREDIT_W    (CREDIT_W),
    .CHANGE_UNIT (CHANGE_UNIT)
  ) u_change (
    .clk            (clk),
    .reset          (reset),
    .load_i         (cu_load),
    .load_val_i     (cu_load_val),
    .start_i        (cu_start),
    .change_ack_i   (change_ack),
    .change_valid_o (cu_valid),
    .remaining_o    (cu_remaining),
    .done_o         (cu_done)
  );

  assign dispense_valid = dispense_valid_q;
  assign dispense_item  = dispense_item_q;
  assign change_valid   = cu_valid;
  assign coin_reject    = coin_reject_q;
  assign insufficient   = insufficient_q;
  assign credit         = credit_q;
  assign busy           = busy_q;

endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
Parametrised vending controller that accumulates credit from multi-denomination coin events and vends one of two items on a selection request. Vends use a valid/ack handshake. Change and cancel refunds are paid out one CHANGE_UNIT coin at a time over a second valid/ack handshake. Sits between the coin-acceptor/keypad front end and the dispenser/hopper actuators.

Parameters:
CREDIT_W, 7, credit register width; must hold MAX_CREDIT
MAX_CREDIT, 60, highest credit accepted; a coin that would exceed it is rejected
COIN_VAL_0, 5, value of coin_sel = 0
COIN_VAL_1, 10, value of coin_sel = 1
COIN_VAL_2, 25, value of coin_sel = 2; coin_sel = 3 is an invalid coin
PRICE_0, 15, price of item 0
PRICE_1, 20, price of item 1
CHANGE_UNIT, 5, value of one refund coin; all coin values and prices are multiples of it (elaboration-time check)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
coin_valid  in  1  one-cycle coin insertion event
coin_sel  in  2  denomination of the inserted coin
sel_valid  in  1  one-cycle item-selection event
sel_item  in  1  selected item index
cancel  in  1  one-cycle refund request
dispense_ack  in  1  dispenser accepted the item
change_ack  in  1  hopper paid one refund coin
dispense_valid  out  1  item dispense request, held until acked
dispense_item  out  1  item index, stable while dispense_valid
change_valid  out  1  refund coin request, held until acked
coin_reject  out  1  one-cycle pulse: coin returned, not credited
insufficient  out  1  one-cycle pulse: selection refused for low credit
credit  out  CREDIT_W  current credit (registered)
busy  out  1  high in VEND and CHANGE

Behaviour:
- All outputs are registered. On reset: state IDLE, credit 0, remaining 0, every output 0. Reset mid-operation forfeits credit and change in flight and drops any handshake immediately.
- States: IDLE (credit = 0), CREDIT (credit > 0), VEND, CHANGE.
- Event priority in IDLE/CREDIT, per cycle: cancel > sel_valid > coin_valid. A coin_valid that loses arbitration gets a coin_reject pulse. A losing sel_valid is ignored.
- Coin handling:
  - Valid denomination with credit + value <= MAX_CREDIT: credit += value next cycle; IDLE -> CREDIT.
  - coin_sel = 3, or a coin that would overflow: coin_reject next cycle, credit unchanged.
- Selection handling:
  - credit >= price: next cycle enter VEND with dispense_valid = 1 and dispense_item = sel_item; remaining = credit - price.
  - Otherwise: insufficient pulse next cycle; credit and state unchanged.
  - A selection in IDLE is treated as credit 0, so it raises insufficient.
- Cancel:
  - In CREDIT: remaining = credit, enter CHANGE.
  - In IDLE: no effect.
- VEND: dispense_valid stays high until a cycle with dispense_ack = 1. That cycle transitions to CHANGE if remaining > 0, else IDLE; the transition also drops dispense_valid and sets credit = remaining.
- CHANGE:
  - change_valid is high while remaining > 0.
  - Each cycle with change_valid and change_ack: remaining and credit both decrease by CHANGE_UNIT.
  - When remaining reaches 0: state goes to IDLE and change_valid drops the same edge.
- In VEND and CHANGE, every coin_valid is rejected (coin_reject pulse); sel_valid and cancel are ignored.
- Acks arriving while the matching valid is low are ignored.
- Credit never exceeds MAX_CREDIT and never goes negative. Arithmetic is done at CREDIT_W+1 bits for the overflow compare.

Decomposition:
- Shared package vend_pkg:
  - state enum (IDLE, CREDIT, VEND, CHANGE)
  - coin_sel encodings, including COIN_INVALID = 2'd3
  - a function mapping coin_sel to value from the parameters
- One natural sub-module, vend_change_unit: holds the remaining counter and the change_valid/change_ack handshake; exposes load, load value, and done.

Test Plan:
- Coins 10, then 5; sel_item 0 -> credit 15; dispense_valid = 1 and item 0 one cycle after sel; held 3 cycles until ack; no change_valid; IDLE, credit 0.
- Coin 25; sel_item 1 -> dispense item 1; after ack, change_valid = 1 for one unit; one change_ack -> credit 0, IDLE.
- Coin 10; sel_item 1 -> single-cycle insufficient, credit stays 10; cancel -> two change handshakes (10 -> 5 -> 0), then IDLE.
- Coins 25, 25, 10 -> credit 60; coin 5 -> coin_reject, credit 60; coin_sel 3 -> coin_reject; coin during VEND -> coin_reject.
- Credit 20; same cycle cancel + sel_valid + coin_valid -> coin_reject pulse; CHANGE with 4 units; no dispense_valid.
- Reset asserted mid-CHANGE with change_ack held high -> all outputs 0 asynchronously; credit 0; after release, a coin of 5 gives credit 5.
